// File: rtl/mult_seq_unit_if.sv
// Operand/result bundle for the sequential multiplier: start/busy/done handshake plus data.
// Latency: none (wires only); timing is owned by mult_seq_unit.
// Backpressure: none; the requester must watch busy, since start is only taken while idle.
interface mult_seq_unit_if;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Requester side: drives the operands, observes progress and the product.
    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    // Multiplier side.
    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_seq_unit.sv
// Iterative 32x32 shift-add multiplier; 64-bit product on {hi, lo}. Optional signed mode under MULT_SIGNED_EN.
// Latency: 34 cycles from accepted start to the done pulse; busy is high for 33 of them.
// Backpressure: start is ignored while busy; a new start may be issued in the done cycle.
module mult_seq_unit (
    input  logic            clk,
    input  logic            rst,
    mult_seq_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [64:0] acc;
    logic [4:0]  cnt;
    logic [31:0] mag_a;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;
    logic [63:0] result;
    logic [32:0] sum;
    logic [64:0] acc_add;

`ifdef MULT_SIGNED_EN
    logic neg_q;
    logic neg_in;

    // Magnitudes are taken only for signed requests; 0x80000000 maps to 2^31, which still fits.
    assign mag_a_in = (bus.is_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    assign mag_b_in = (bus.is_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    assign neg_in   = bus.is_signed & (bus.a[31] ^ bus.b[31]);
    assign result   = neg_q ? (~acc[63:0] + 64'd1) : acc[63:0];
`else
    // Unsigned-only build: is_signed has no effect and the product is written as accumulated.
    logic unused_is_signed;
    assign unused_is_signed = bus.is_signed;
    assign mag_a_in = bus.a;
    assign mag_b_in = bus.b;
    assign result   = acc[63:0];
`endif

    // One shift-add step: add the multiplicand into the top half when the current multiplier bit is set.
    assign sum     = {1'b0, acc[63:32]} + {1'b0, mag_a};
    assign acc_add = acc[0] ? {sum, acc[31:0]} : acc;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Control FSM with the datapath registers and registered outputs; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            mag_a  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef MULT_SIGNED_EN
            neg_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mag_a  <= mag_a_in;
                        acc    <= {33'd0, mag_b_in};
                        cnt    <= '0;
                        busy_q <= 1'b1;
`ifdef MULT_SIGNED_EN
                        neg_q  <= neg_in;
`endif
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_add >> 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    hi_q   <= result[63:32];
                    lo_q   <= result[31:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
